gray_step_monitor: RTL and testbench
====================================

// Module: gray_step_monitor
// PURPOSE
//  Downstream consumer of the gray_c counter output. It samples an N-bit gray code,
//  decodes it to binary (1-cycle latency) and checks each new code against the previous
//  one. A legal step is +1 mod 2^N, optionally a hold. A lock FSM qualifies the stream,
//  and illegal steps are flagged and counted in a saturating error counter.
// PARAMETERS
//  N          4  gray/binary width
//  LOCK_CNT   4  consecutive legal steps needed to declare lock (>=1)
//  ALLOW_HOLD 1  1: an unchanged code is legal (no lock progress); 0: a hold is an error
//  CW         8  width of the error counter
// PORTS
//  clk        in   1     rising-edge clock
//  rstn       in   1     asynchronous active-low reset
//  in_valid   in   1     gray_in is sampled this cycle
//  gray_in    in   N     gray code from the upstream counter
//  clear_err  in   1     synchronous clear of err_cnt
//  bin_valid  out  1     bin_out updated (in_valid delayed by 1)
//  bin_out    out  N     binary decode of the last sampled gray_in
//  step_err   out  1     1-cycle pulse: the last sample was an illegal step
//  locked     out  1     FSM is in LOCKED
//  err_cnt    out  CW    saturating count of illegal steps
// BEHAVIOUR
//  - Reset: async assert. Every output and register goes to 0, the FSM to IDLE and the
//    'prev' register is marked invalid. Deassertion is used synchronously.
//  - Decode: b[N-1]=g[N-1]; b[i]=b[i+1]^g[i]. It is registered, so bin_out/bin_valid
//    follow in_valid by exactly 1 cycle. With in_valid=0, bin_out holds and bin_valid=0.
//  - Classification (only when in_valid=1 and prev is valid), with b = new binary:
//    HOLD: g==prev_g.  STEP: b==prev_b+1 mod 2^N, so 2^N-1 -> 0 is legal.  BAD: otherwise.
//    With ALLOW_HOLD=0, HOLD counts as BAD.
//  - prev_g/prev_b update on every accepted sample, including BAD ones: resync to the
//    new value.
//  - FSM (advances only on in_valid):
//    IDLE    -> ACQUIRE on the first sample (stores prev, no check); run=0.
//    ACQUIRE: STEP run++ and -> LOCKED when run reaches LOCK_CNT; HOLD keeps run;
//             BAD run=0.
//    LOCKED:  STEP/HOLD stay; BAD -> ACQUIRE with run=0.
//  - step_err: asserts with bin_valid for a BAD sample in ACQUIRE or LOCKED.
//  - locked: registered from the state; rises in the same cycle as the bin_valid of
//    the locking sample.
//  - err_cnt: +1 per BAD and saturates at 2^CW-1.
//    clear_err alone -> 0; clear_err with a BAD in the same cycle -> 1.
//  - Reset mid-stream: everything returns to IDLE. The next sample is a fresh
//    reference, not an error.
//  - The upstream counter repeats 0 once after its reset, so use ALLOW_HOLD=1 with it.
// STRUCTURE
//  - gray_pkg: state_e {IDLE,ACQUIRE,LOCKED}, step_e {HOLD,STEP,BAD},
//    function gray2bin #N.
//  - Sub-module gray2bin_comb: combinational decoder of width N, reused by other
//    consumers.
//  - Top level holds the prev regs, classifier, FSM, run counter (clog2(LOCK_CNT+1)),
//    err counter and output regs.
// TESTING (N=4, LOCK_CNT=4, CW=8 unless noted)
//  1. rstn low, then gray 0,1,3,2,6 with in_valid=1 ->
//     bin_out 0,1,2,3,4 each 1 cycle late; locked=1 with bin 4.
//  2. Locked at bin 15 (gray 1000), next gray 0000 -> STEP, locked stays 1, step_err=0.
//  3. Locked, gray 0110 then 0101 (bin 4 -> 6) -> step_err pulse, locked=0, err_cnt=1;
//     4 more legal steps relock.
//  4. ALLOW_HOLD=0, gray repeat 0011,0011 while locked -> BAD, err_cnt+1.
//     ALLOW_HOLD=1 -> no error.
//  5. CW=2, force 5 BAD steps -> err_cnt 1,2,3,3,3.
//     clear_err with a BAD in the same cycle -> 1.
//  6. Pulse rstn low mid-stream while locked -> all outputs 0 immediately.
//     Next sample gives no step_err; lock needs 4 new steps.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types and helpers for gray-code stream consumers.
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } state_e;

    typedef enum logic [1:0] {
        HOLD,
        STEP,
        BAD
    } step_e;

    // Bits of g at and above n must be zero; each binary bit is the xor of all
    // gray bits at or above its position.
    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int n);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Combinational N-bit gray to binary decoder.
module gray2bin_comb #(
    parameter int N = 4
) (
    input  logic [N-1:0] gray,
    input  logic [N-1:0] bin_unused_tie,
    output logic [N-1:0] bin
);
    logic [N-1:0] tie_sink;

    // Written as a reduction of the upper gray bits so no bit of bin depends on another.
    always_comb begin
        bin = '0;
        for (int i = 0; i < N; i++) begin
            bin[i] = ^(gray >> i);
        end
        tie_sink = bin_unused_tie;
    end
endmodule

// File: rtl/gray_step_monitor.sv
// Samples a gray-coded counter stream, decodes it to binary and qualifies each step.
//
// state   | meaning
// IDLE    | no reference sample held
// ACQUIRE | counting consecutive legal steps toward lock
// LOCKED  | stream qualified; a bad step drops back to ACQUIRE
module gray_step_monitor
    import gray_pkg::*;
#(
    parameter int N          = 4,
    parameter int LOCK_CNT   = 4,
    parameter int ALLOW_HOLD = 1,
    parameter int CW         = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    input  logic [N-1:0]  gray_in,
    input  logic          clear_err,
    output logic          bin_valid,
    output logic [N-1:0]  bin_out,
    output logic          step_err,
    output logic          locked,
    output logic [CW-1:0] err_cnt
);
    localparam int RW = $clog2(LOCK_CNT + 1);

    logic [N-1:0]  bin_new;
    logic [N-1:0]  prev_g;
    logic [N-1:0]  prev_b;
    logic          prev_valid;
    logic [RW-1:0] run;
    state_e        state;
    step_e         step;
    logic          bad;

    gray2bin_comb #(.N(N)) u_dec (
        .gray           (gray_in),
        .bin_unused_tie ('0),
        .bin            (bin_new)
    );

    always_comb begin
        step = BAD;
        if (gray_in == prev_g) begin
            step = (ALLOW_HOLD != 0) ? HOLD : BAD;
        end else if (bin_new == prev_b + N'(1)) begin
            step = STEP;
        end
    end

    // The first sample after reset is only a reference and can never be bad.
    assign bad = in_valid && prev_valid && (step == BAD);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            run        <= '0;
            prev_g     <= '0;
            prev_b     <= '0;
            prev_valid <= 1'b0;
            bin_valid  <= 1'b0;
            bin_out    <= '0;
            step_err   <= 1'b0;
            locked     <= 1'b0;
            err_cnt    <= '0;
        end else begin
            bin_valid <= in_valid;
            step_err  <= bad;

            if (in_valid) begin
                bin_out    <= bin_new;
                prev_g     <= gray_in;
                prev_b     <= bin_new;
                prev_valid <= 1'b1;

                case (state)
                    IDLE: begin
                        state <= ACQUIRE;
                        run   <= '0;
                    end
                    ACQUIRE: begin
                        if (step == STEP) begin
                            if (run == RW'(LOCK_CNT - 1)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                run    <= '0;
                            end else begin
                                run <= run + RW'(1);
                            end
                        end else if (step == BAD) begin
                            run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (step == BAD) begin
                            state  <= ACQUIRE;
                            locked <= 1'b0;
                            run    <= '0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                        run    <= '0;
                    end
                endcase
            end

            // A bad step in the clearing cycle is still counted.
            if (clear_err) begin
                err_cnt <= bad ? CW'(1) : '0;
            end else if (bad && (err_cnt != {CW{1'b1}})) begin
                err_cnt <= err_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_gray_step_monitor.sv
// Randomised scoreboard bench: three monitor configurations share one stimulus stream.
module tb_gray_step_monitor;
    logic       clk;
    logic       rstn;
    logic       in_valid;
    logic [3:0] gray_in;
    logic       clear_err;

    logic       bv0, bv1, bv2;
    logic [3:0] bo0, bo1, bo2;
    logic       se0, se1, se2;
    logic       lk0, lk1, lk2;
    logic [7:0] ec0, ec1;
    logic [1:0] ec2;

    gray_step_monitor #(.N(4), .LOCK_CNT(4), .ALLOW_HOLD(1), .CW(8)) u_dut0 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .gray_in(gray_in), .clear_err(clear_err),
        .bin_valid(bv0), .bin_out(bo0), .step_err(se0), .locked(lk0), .err_cnt(ec0));
    gray_step_monitor #(.N(4), .LOCK_CNT(4), .ALLOW_HOLD(0), .CW(8)) u_dut1 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .gray_in(gray_in), .clear_err(clear_err),
        .bin_valid(bv1), .bin_out(bo1), .step_err(se1), .locked(lk1), .err_cnt(ec1));
    gray_step_monitor #(.N(4), .LOCK_CNT(4), .ALLOW_HOLD(1), .CW(2)) u_dut2 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .gray_in(gray_in), .clear_err(clear_err),
        .bin_valid(bv2), .bin_out(bo2), .step_err(se2), .locked(lk2), .err_cnt(ec2));

    typedef struct packed {
        int              cyc;
        logic [2:0]      vld;
        logic [2:0][3:0] bin;
        logic [2:0]      serr;
        logic [2:0]      lk;
        logic [2:0][7:0] err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model state, one entry per configuration.
    bit   allow_hold[3] = '{1, 0, 1};
    int   err_max[3]    = '{255, 255, 3};
    bit   m_have[3];
    int   m_ref[3];
    int   m_run[3];
    bit   m_lk[3];
    int   m_err[3];
    int   m_last[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int dut, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0d required=%0d at %0t", name, dut, act, exp, $time);
        end
    endtask

    function automatic int g2b(input int g);
        int b = 0;
        for (int s = 0; s < 4; s++) b = b ^ (g >> s);
        return b & 15;
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_have[i] = 0; m_ref[i] = 0; m_run[i] = 0;
            m_lk[i] = 0; m_err[i] = 0; m_last[i] = 0;
        end
    endtask

    task automatic drive(input bit v, input int g, input bit clr);
        exp_t e;
        int   b;
        bit   bad, stp;
        @(posedge clk);
        #1;
        in_valid  = v;
        gray_in   = 4'(g);
        clear_err = clr;
        e     = '0;
        e.cyc = cyc;
        b     = g2b(g);
        for (int i = 0; i < 3; i++) begin
            bad = 0;
            stp = 0;
            if (v) begin
                if (m_have[i]) begin
                    if (b == m_ref[i])               bad = !allow_hold[i];
                    else if (b == (m_ref[i] + 1) % 16) stp = 1;
                    else                              bad = 1;
                    if (!m_lk[i]) begin
                        if (stp) begin
                            m_run[i]++;
                            if (m_run[i] >= 4) begin m_lk[i] = 1; m_run[i] = 0; end
                        end else if (bad) m_run[i] = 0;
                    end else if (bad) begin
                        m_lk[i] = 0; m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_have[i] = 1;
                m_ref[i]  = b;
                m_last[i] = b;
            end
            if (clr)                            m_err[i] = bad ? 1 : 0;
            else if (bad && m_err[i] < err_max[i]) m_err[i]++;
            e.vld[i]  = v;
            e.bin[i]  = 4'(m_last[i]);
            e.serr[i] = bad;
            e.lk[i]   = m_lk[i];
            e.err[i]  = 8'(m_err[i]);
        end
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        in_valid  = 0;
        clear_err = 0;
        rstn      = 0;
        q.delete();
        model_reset();
        #1;
        chk("rst_bin_valid", 0, int'({bv2, bv1, bv0}), 0);
        chk("rst_bin_out",   0, int'({bo2, bo1, bo0}), 0);
        chk("rst_step_err",  0, int'({se2, se1, se0}), 0);
        chk("rst_locked",    0, int'({lk2, lk1, lk0}), 0);
        chk("rst_err_cnt",   0, int'({ec2, ec1, ec0}), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1;
    endtask

    always @(negedge clk) begin
        if (rstn && q.size() > 0 && q[0].cyc < cyc) begin
            exp_t            e;
            logic [2:0]      a_bv, a_se, a_lk;
            logic [2:0][3:0] a_bo;
            logic [2:0][7:0] a_ec;
            e    = q.pop_front();
            a_bv = {bv2, bv1, bv0};
            a_se = {se2, se1, se0};
            a_lk = {lk2, lk1, lk0};
            a_bo = {bo2, bo1, bo0};
            a_ec = {{6'b0, ec2}, ec1, ec0};
            for (int i = 0; i < 3; i++) begin
                chk("bin_valid", i, int'(a_bv[i]), int'(e.vld[i]));
                chk("bin_out",   i, int'(a_bo[i]), int'(e.bin[i]));
                chk("step_err",  i, int'(a_se[i]), int'(e.serr[i]));
                chk("locked",    i, int'(a_lk[i]), int'(e.lk[i]));
                chk("err_cnt",   i, int'(a_ec[i]), int'(e.err[i]));
            end
        end
    end

    initial begin
        int cur, r, nxt;
        in_valid  = 0;
        gray_in   = 0;
        clear_err = 0;
        rstn      = 1;
        model_reset();
        do_reset();

        // Acquire and lock, then wrap 15 -> 0 while locked.
        for (int b = 0; b <= 15; b++) drive(1, b2g(b), 0);
        drive(1, b2g(0), 0);
        // Gap, then a jump 4 -> 6 and relock.
        for (int b = 1; b <= 4; b++) drive(1, b2g(b), 0);
        drive(0, 0, 0);
        drive(1, b2g(6), 0);
        for (int b = 7; b <= 10; b++) drive(1, b2g(b), 0);
        // Holds while locked.
        drive(1, b2g(10), 0);
        drive(1, b2g(10), 0);
        // Repeated bad jumps saturate the narrow counter, then clear with and without a bad.
        for (int k = 1; k <= 5; k++) drive(1, b2g((10 + 3 * k) % 16), 0);
        drive(1, b2g(12), 1);
        drive(1, b2g(13), 0);
        drive(0, 0, 1);
        for (int b = 14; b <= 18; b++) drive(1, b2g(b % 16), 0);
        // Reset mid-stream while locked; next sample is a fresh reference.
        do_reset();
        for (int b = 7; b <= 12; b++) drive(1, b2g(b), 0);

        cur = 12;
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            r = $urandom_range(0, 99);
            if (r < 75)      nxt = (cur + 1) % 16;
            else if (r < 87) nxt = cur;
            else             nxt = $urandom_range(0, 15);
            if ($urandom_range(0, 4) == 0) begin
                drive(0, $urandom_range(0, 15), $urandom_range(0, 31) == 0);
            end else begin
                drive(1, b2g(nxt), $urandom_range(0, 31) == 0);
                cur = nxt;
            end
        end
        repeat (3) drive(0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 0, q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
